// File: rtl/i2s_rx.sv
// I2S receiver front end: oversamples SCK/WS/SD on clk, deserializes stereo
// two's-complement words and presents each completed left/right pair with a
// one-cycle sample_valid strobe. Malformed slots/frames pulse frame_err.
module i2s_rx #(
    parameter int WD_OUT      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2s_sck,
    input  logic              i2s_ws,
    input  logic              i2s_sd,
    output logic [WD_OUT-1:0] data_left,
    output logic [WD_OUT-1:0] data_right,
    output logic              sample_valid,
    output logic              frame_err
);

    localparam int CW = $clog2(WD_OUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    // Synchronizers and registered edge detection
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ws_sync_r;
    logic [SYNC_STAGES-1:0] sd_sync_r;
    logic                   sck_dly_r;
    logic                   rise_r;
    logic                   ws_smp_r;
    logic                   sd_smp_r;

    // Frame state
    state_t                 state_r,      state_nxt_s;
    logic [CW-1:0]          bit_cnt_r,    bit_cnt_nxt_s;
    logic                   chan_r,       chan_nxt_s;
    logic [WD_OUT-2:0]      shreg_r,      shreg_nxt_s;
    logic [WD_OUT-1:0]      left_shadow_r, left_shadow_nxt_s;
    logic                   left_ok_r,    left_ok_nxt_s;
    logic                   ws_prev_r,    ws_prev_nxt_s;
    logic [WD_OUT-1:0]      data_left_nxt_s;
    logic [WD_OUT-1:0]      data_right_nxt_s;
    logic                   sample_valid_nxt_s;
    logic                   frame_err_nxt_s;

    logic                   ws_edge_s;
    logic [WD_OUT-1:0]      word_s;
    logic [CW-1:0]          cnt_inc_s;

    // Bring the asynchronous bus into clk and flag SCK rises one cycle later,
    // with WS/SD captured alongside so they stay aligned with the rise flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_r <= '0;
            ws_sync_r  <= '0;
            sd_sync_r  <= '0;
            sck_dly_r  <= 1'b0;
            rise_r     <= 1'b0;
            ws_smp_r   <= 1'b0;
            sd_smp_r   <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], i2s_sck};
            ws_sync_r  <= {ws_sync_r[SYNC_STAGES-2:0], i2s_ws};
            sd_sync_r  <= {sd_sync_r[SYNC_STAGES-2:0], i2s_sd};
            sck_dly_r  <= sck_sync_r[SYNC_STAGES-1];
            rise_r     <= sck_sync_r[SYNC_STAGES-1] & ~sck_dly_r;
            ws_smp_r   <= ws_sync_r[SYNC_STAGES-1];
            sd_smp_r   <= sd_sync_r[SYNC_STAGES-1];
        end
    end

    assign ws_edge_s = rise_r & (ws_smp_r != ws_prev_r);
    assign word_s    = {shreg_r, sd_smp_r};
    assign cnt_inc_s = bit_cnt_r + CW'(1);

    // Next-state and datapath decisions, evaluated only on SCK-rise cycles
    always_comb begin
        state_nxt_s        = state_r;
        bit_cnt_nxt_s      = bit_cnt_r;
        chan_nxt_s         = chan_r;
        shreg_nxt_s        = shreg_r;
        left_shadow_nxt_s  = left_shadow_r;
        left_ok_nxt_s      = left_ok_r;
        ws_prev_nxt_s      = ws_prev_r;
        data_left_nxt_s    = data_left;
        data_right_nxt_s   = data_right;
        sample_valid_nxt_s = 1'b0;
        frame_err_nxt_s    = 1'b0;
        if (rise_r) begin
            ws_prev_nxt_s = ws_smp_r;
            case (state_r)
                ST_IDLE: begin
                    // only a fall to left starts capture, so pairs always begin left
                    if (ws_edge_s && !ws_smp_r) begin
                        state_nxt_s   = ST_SHIFT;
                        bit_cnt_nxt_s = '0;
                        chan_nxt_s    = 1'b0;
                        shreg_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (ws_edge_s) begin
                        // slot ended early: drop the partial word, restart on new channel
                        frame_err_nxt_s = 1'b1;
                        state_nxt_s     = ST_SHIFT;
                        bit_cnt_nxt_s   = '0;
                        chan_nxt_s      = ws_smp_r;
                        shreg_nxt_s     = '0;
                    end else begin
                        shreg_nxt_s   = word_s[WD_OUT-2:0];
                        bit_cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CW'(WD_OUT)) begin
                            state_nxt_s = ST_PAD;
                            if (!chan_r) begin
                                left_shadow_nxt_s = word_s;
                                left_ok_nxt_s     = 1'b1;
                            end else if (left_ok_r) begin
                                data_left_nxt_s    = left_shadow_r;
                                data_right_nxt_s   = word_s;
                                sample_valid_nxt_s = 1'b1;
                                left_ok_nxt_s      = 1'b0;
                            end else begin
                                frame_err_nxt_s = 1'b1;
                            end
                        end else begin
                            state_nxt_s = ST_SHIFT;
                        end
                    end
                end
                ST_PAD: begin
                    if (ws_edge_s) begin
                        state_nxt_s   = ST_SHIFT;
                        bit_cnt_nxt_s = '0;
                        chan_nxt_s    = ws_smp_r;
                        shreg_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= '0;
            chan_r        <= 1'b0;
            shreg_r       <= '0;
            left_shadow_r <= '0;
            left_ok_r     <= 1'b0;
            ws_prev_r     <= 1'b0;
            data_left     <= '0;
            data_right    <= '0;
            sample_valid  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            bit_cnt_r     <= bit_cnt_nxt_s;
            chan_r        <= chan_nxt_s;
            shreg_r       <= shreg_nxt_s;
            left_shadow_r <= left_shadow_nxt_s;
            left_ok_r     <= left_ok_nxt_s;
            ws_prev_r     <= ws_prev_nxt_s;
            data_left     <= data_left_nxt_s;
            data_right    <= data_right_nxt_s;
            sample_valid  <= sample_valid_nxt_s;
            frame_err     <= frame_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives I2S slots at the bit level and
// compares delivered pairs, error pulses and latency against a slot-level model.
module tb_i2s_rx;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i2s_sck = 1'b0;
    logic         i2s_ws = 1'b0;
    logic         i2s_sd = 1'b0;
    logic [W-1:0] data_left;
    logic [W-1:0] data_right;
    logic         sample_valid;
    logic         frame_err;

    i2s_rx #(.WD_OUT(W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .data_left    (data_left),
        .data_right   (data_right),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed events
    int          cyc_m = 0;
    logic [47:0] got_q[$];
    int          err_cnt = 0;
    int          last_pulse_cyc = 0;

    // Reference model state (slot level)
    logic [47:0] exp_q[$];
    int          exp_err = 0;
    bit          started_m = 1'b0;
    bit          left_ok_m = 1'b0;
    bit          last_ws_m = 1'b0;
    bit          pend_m = 1'b0;
    logic [W-1:0] shadow_m = '0;
    logic [47:0] last_pair_m = '0;

    int half = 4;
    int last_rise = 0;
    int lsb_rise = 0;

    // Record output pulses shortly after each active edge
    always @(posedge clk) begin
        cyc_m++;
        #1;
        if (sample_valid === 1'b1) begin
            got_q.push_back({data_left, data_right});
            last_pulse_cyc = cyc_m;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One SCK period: WS/SD change with SCK falling, then SCK high
    task automatic drive_bit(input logic ws, input logic sd);
        i2s_sck = 1'b0;
        i2s_ws  = ws;
        i2s_sd  = sd;
        repeat (half) @(negedge clk);
        i2s_sck = 1'b1;
        last_rise = cyc_m + 1;
        repeat (half) @(negedge clk);
    endtask

    task automatic model_reset();
        started_m   = 1'b0;
        left_ok_m   = 1'b0;
        last_ws_m   = 1'b0;
        pend_m      = 1'b0;
        shadow_m    = '0;
        last_pair_m = '0;
    endtask

    // One WS period of len SCK periods: a delay bit, then word MSB first, then padding
    task automatic send_slot(input bit ch, input int len, input logic [W-1:0] word);
        bit edge_b;
        logic b_v;
        edge_b = (ch != last_ws_m);
        if (edge_b) begin
            if (pend_m) exp_err++;
            pend_m = 1'b0;
            if (!started_m && ch == 1'b0) started_m = 1'b1;
            last_ws_m = ch;
        end
        for (int b = 0; b < len; b++) begin
            if (b >= 1 && b <= W) b_v = word[W-b];
            else b_v = 1'($urandom);
            drive_bit(ch, b_v);
            if (b == W) lsb_rise = last_rise;
        end
        if (started_m && edge_b) begin
            if (len - 1 >= W) begin
                if (ch == 1'b0) begin
                    shadow_m  = word;
                    left_ok_m = 1'b1;
                end else if (left_ok_m) begin
                    last_pair_m = {shadow_m, word};
                    exp_q.push_back(last_pair_m);
                    left_ok_m = 1'b0;
                end else begin
                    exp_err++;
                end
            end else begin
                pend_m = 1'b1;
            end
        end
    endtask

    task automatic checkpoint(input string tag);
        repeat (4) @(negedge clk);
        check({tag, " pair count"}, 48'(got_q.size()), 48'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, " pair data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, " frame_err count"}, 48'(err_cnt), 48'(exp_err));
        check({tag, " data_left hold"}, 48'(data_left), 48'(last_pair_m[47:24]));
        check({tag, " data_right hold"}, 48'(data_right), 48'(last_pair_m[23:0]));
    endtask

    initial begin
        logic [W-1:0] lv;
        logic [W-1:0] rv;

        // Reset held while the bus toggles
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i2s_sck = ~i2s_sck;
            i2s_ws  = 1'($urandom);
            i2s_sd  = 1'($urandom);
        end
        check("reset data_left", 48'(data_left), 48'h0);
        check("reset data_right", 48'(data_right), 48'h0);
        check("reset pulses", {46'h0, sample_valid, frame_err}, 48'h0);
        check("reset no events", 48'(got_q.size() + err_cnt), 48'h0);

        // Release during a right slot; the partial slot must be ignored
        i2s_ws  = 1'b1;
        i2s_sck = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        half = 4;
        send_slot(1'b1, 12, W'($urandom));
        send_slot(1'b0, 25, 24'h123456);
        send_slot(1'b1, 25, 24'hABCDEF);
        checkpoint("midframe");

        // Nominal 32-bit slots at clk/32 with latency check
        half = 16;
        send_slot(1'b0, 32, 24'h7FFFFF);
        send_slot(1'b1, 32, 24'h800001);
        check("latency", 48'(last_pulse_cyc), 48'(lsb_rise + 3));
        checkpoint("nominal");

        // Short left slot, then an orphan right word
        half = 4;
        send_slot(1'b0, 16, W'($urandom));
        send_slot(1'b1, 25, 24'h000001);
        checkpoint("short slot");

        // Tight framing: 100 frames of a full-scale ramp
        for (int i = 0; i < 100; i++) begin
            lv = 24'h800000 + 24'(i * 169466);
            rv = 24'h7FFFFF - 24'(i * 169466);
            send_slot(1'b0, 25, lv);
            send_slot(1'b1, 25, rv);
        end
        checkpoint("ramp");

        // Random words with random padded slot lengths
        for (int i = 0; i < 20; i++) begin
            send_slot(1'b0, $urandom_range(25, 32), W'($urandom));
            send_slot(1'b1, $urandom_range(25, 32), W'($urandom));
        end
        checkpoint("random");

        // Reset after 10 right bits
        send_slot(1'b0, 25, W'($urandom));
        send_slot(1'b1, 11, W'($urandom));
        i2s_sck = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("midreset data_left", 48'(data_left), 48'h0);
        check("midreset data_right", 48'(data_right), 48'h0);
        reset_n = 1'b1;
        send_slot(1'b1, 14, W'($urandom));
        send_slot(1'b0, 25, 24'h000010);
        send_slot(1'b1, 25, 24'hFFFFF0);
        checkpoint("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
